// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives PC advance/branch controls from stall, branch, halt requests.
// Optional perf counters are built when FETCH_SEQ_PERF_EN is defined.
module fetch_sequencer #(
  parameter int FLUSH_CYCLES = 4
) (
  input  logic        clka,
  input  logic        restart,
  input  logic        stall_in,
  input  logic        branch_req,
  input  logic [7:0]  branch_target,
  input  logic        halt_in,
  input  logic        resume_in,
  output logic        pc_en,
  output logic        branch_taken_out,
  output logic [7:0]  branch_immediate_out,
  output logic        flush_out,
  output logic        fetch_valid,
  output logic [2:0]  state_out,
  output logic [15:0] stall_cycles_out,
  output logic [15:0] flush_events_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STALL = 3'd2,
    S_FLUSH = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_flush_cnt;
  logic        r_branch_taken;
  logic [7:0]  r_branch_imm;
  logic        w_accept;

  // Branches are only honoured on the architectural path (RUN or STALL).
  assign w_accept = ((r_state == S_RUN) || (r_state == S_STALL)) && branch_req;

  always_ff @(negedge clka or posedge restart) begin
    if (restart) begin
      r_state        <= S_IDLE;
      r_flush_cnt    <= 4'd0;
      r_branch_taken <= 1'b0;
      r_branch_imm   <= 8'h00;
    end else begin
      r_branch_taken <= 1'b0;
      case (r_state)
        S_IDLE: r_state <= S_RUN;
        S_RUN, S_STALL: begin
          if (w_accept) begin
            r_state        <= S_FLUSH;
            r_flush_cnt    <= FLUSH_LOAD;
            r_branch_taken <= 1'b1;
            r_branch_imm   <= branch_target;
          end else if (halt_in) begin
            r_state <= S_HALT;
          end else if (stall_in) begin
            r_state <= S_STALL;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_FLUSH: begin
          if (r_flush_cnt == 4'd0) begin
            r_state <= S_RUN;
          end else begin
            r_flush_cnt <= r_flush_cnt - 4'd1;
          end
        end
        S_HALT: begin
          if (resume_in) begin
            r_state <= S_RUN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // pc_en stays high through FLUSH so the PC drains its delayed branch flag.
  assign pc_en                = (r_state == S_RUN) || (r_state == S_FLUSH);
  assign fetch_valid          = (r_state == S_RUN);
  assign flush_out            = (r_state == S_FLUSH);
  assign branch_taken_out     = r_branch_taken;
  assign branch_immediate_out = r_branch_imm;
  assign state_out            = r_state;

`ifdef FETCH_SEQ_PERF_EN
  logic [15:0] r_stall_cycles;
  logic [15:0] r_flush_events;

  always_ff @(negedge clka or posedge restart) begin
    if (restart) begin
      r_stall_cycles <= 16'h0000;
      r_flush_events <= 16'h0000;
    end else begin
      if ((r_state == S_STALL) && (r_stall_cycles != 16'hFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
      if (w_accept && (r_flush_events != 16'hFFFF)) begin
        r_flush_events <= r_flush_events + 16'd1;
      end
    end
  end

  assign stall_cycles_out = r_stall_cycles;
  assign flush_events_out = r_flush_events;
`else
  assign stall_cycles_out = 16'h0000;
  assign flush_events_out = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; expectations are hand-computed.
module tb_fetch_sequencer;

  logic        clka = 1'b0;
  logic        restart = 1'b0;
  logic        stall_in = 1'b0;
  logic        branch_req = 1'b0;
  logic [7:0]  branch_target = 8'h00;
  logic        halt_in = 1'b0;
  logic        resume_in = 1'b0;
  logic        pc_en;
  logic        branch_taken_out;
  logic [7:0]  branch_immediate_out;
  logic        flush_out;
  logic        fetch_valid;
  logic [2:0]  state_out;
  logic [15:0] stall_cycles_out;
  logic [15:0] flush_events_out;

  int n_checks = 0;
  int n_errors = 0;
  int n_cyc    = 0;

`ifdef FETCH_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  fetch_sequencer #(.FLUSH_CYCLES(4)) dut (
    .clka                 (clka),
    .restart              (restart),
    .stall_in             (stall_in),
    .branch_req           (branch_req),
    .branch_target        (branch_target),
    .halt_in              (halt_in),
    .resume_in            (resume_in),
    .pc_en                (pc_en),
    .branch_taken_out     (branch_taken_out),
    .branch_immediate_out (branch_immediate_out),
    .flush_out            (flush_out),
    .fetch_valid          (fetch_valid),
    .state_out            (state_out),
    .stall_cycles_out     (stall_cycles_out),
    .flush_events_out     (flush_events_out)
  );

  always #5 clka = ~clka;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One active (negative) edge, then sample 1 time unit later.
  task automatic tick();
    @(negedge clka);
    #1;
    n_cyc++;
    $display("cyc %0d: state=%0d pc_en=%0b fv=%0b flush=%0b taken=%0b imm=%h",
             n_cyc, state_out, pc_en, fetch_valid, flush_out, branch_taken_out,
             branch_immediate_out);
  endtask

  // Moore outputs for a given state: {pc_en, fetch_valid, flush_out}
  task automatic check_state(input string tag, input logic [2:0] st);
    logic [2:0] exp_ctl;
    case (st)
      3'd1:    exp_ctl = 3'b110;
      3'd3:    exp_ctl = 3'b101;
      default: exp_ctl = 3'b000;
    endcase
    check_eq({tag, ".state"}, 16'(state_out), 16'(st));
    check_eq({tag, ".ctl"}, 16'({pc_en, fetch_valid, flush_out}), 16'(exp_ctl));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    #2 restart = 1'b1;
    @(negedge clka);
    #1;
    check_state("rst", 3'd0);
    check_eq("rst.taken", 16'(branch_taken_out), 16'd0);
    check_eq("rst.imm", 16'(branch_immediate_out), 16'h00);
    check_eq("rst.stallcnt", stall_cycles_out, 16'h0);
    check_eq("rst.flushcnt", flush_events_out, 16'h0);
    restart = 1'b0;

    // Release: IDLE -> RUN on first edge
    tick();
    check_state("rel", 3'd1);

    // Branch to 3C
    branch_req = 1'b1; branch_target = 8'h3C;
    tick();
    branch_req = 1'b0; branch_target = 8'h00;
    check_state("br.f0", 3'd3);
    check_eq("br.taken0", 16'(branch_taken_out), 16'd1);
    check_eq("br.imm", 16'(branch_immediate_out), 16'h3C);
    for (int i = 1; i < 4; i++) begin
      tick();
      check_state("br.fl", 3'd3);
      check_eq("br.taken_low", 16'(branch_taken_out), 16'd0);
      check_eq("br.imm_hold", 16'(branch_immediate_out), 16'h3C);
    end
    tick();
    check_state("br.run", 3'd1);
    check_eq("br.flushcnt", flush_events_out, PERF ? 16'd1 : 16'd0);

    // Stall held 3 cycles
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_state("stall", 3'd2);
    end
    stall_in = 1'b0;
    tick();
    check_state("stall.run", 3'd1);
    check_eq("stall.cnt", stall_cycles_out, PERF ? 16'd3 : 16'd0);

    // Simultaneous requests: branch wins; later branch during FLUSH ignored
    branch_req = 1'b1; halt_in = 1'b1; stall_in = 1'b1; branch_target = 8'h3C;
    tick();
    check_state("prio", 3'd3);
    check_eq("prio.taken", 16'(branch_taken_out), 16'd1);
    branch_target = 8'h10;
    for (int i = 1; i < 4; i++) begin
      tick();
      check_state("prio.fl", 3'd3);
      check_eq("prio.imm", 16'(branch_immediate_out), 16'h3C);
      check_eq("prio.taken_low", 16'(branch_taken_out), 16'd0);
    end
    tick();
    check_state("prio.run", 3'd1);
    branch_req = 1'b0; halt_in = 1'b0; stall_in = 1'b0;
    check_eq("prio.flushcnt", flush_events_out, PERF ? 16'd2 : 16'd0);
    check_eq("prio.stallcnt", stall_cycles_out, PERF ? 16'd3 : 16'd0);

    // Halt, ignoring branch and stall for 10 cycles
    halt_in = 1'b1;
    tick();
    check_state("halt", 3'd4);
    halt_in = 1'b0; branch_req = 1'b1; stall_in = 1'b1; branch_target = 8'hA5;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_state("halt.hold", 3'd4);
    end
    check_eq("halt.imm", 16'(branch_immediate_out), 16'h3C);
    branch_req = 1'b0; stall_in = 1'b0; resume_in = 1'b1;
    tick();
    resume_in = 1'b0;
    check_state("resume", 3'd1);

    // Restart on the 2nd FLUSH cycle
    branch_req = 1'b1; branch_target = 8'h55;
    tick();
    branch_req = 1'b0;
    check_state("rb.f0", 3'd3);
    check_eq("rb.imm", 16'(branch_immediate_out), 16'h55);
    tick();
    check_state("rb.f1", 3'd3);
    #2 restart = 1'b1;
    #1;
    check_state("rb.rst", 3'd0);
    check_eq("rb.taken", 16'(branch_taken_out), 16'd0);
    check_eq("rb.imm0", 16'(branch_immediate_out), 16'h00);
    check_eq("rb.stallcnt", stall_cycles_out, 16'h0);
    check_eq("rb.flushcnt", flush_events_out, 16'h0);
    #1 restart = 1'b0;
    tick();
    check_state("rb.run", 3'd1);
    check_eq("rb.imm_run", 16'(branch_immediate_out), 16'h00);
    tick();
    check_state("rb.run2", 3'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controls when the 8-bit program counter advances or jumps. It drives the PC's `pc_en`, `branch_taken_in` and `branch_immediate_in` inputs from pipeline stall, branch-resolve and halt requests. It also holds off fetch validity for the fixed branch-shadow latency while the PC's internal branch pipeline drains. It sits between the decode/execute control logic and the program counter, on the same `clka` domain.

## Interface
- `FLUSH_CYCLES`, default 4: cycles spent in FLUSH after an accepted branch. Must equal the PC's branch pipeline depth. Legal range 1–15.
- `clka`  in  1: clock; all state updates on negedge `clka`.
- `restart`  in  1: reset, asynchronous, active-high.
- `stall_in`  in  1: downstream hazard; hold the PC.
- `branch_req`  in  1: execute stage resolved a taken branch this cycle.
- `branch_target`  in  8: target address, valid with `branch_req`.
- `halt_in`  in  1: halt instruction decoded.
- `resume_in`  in  1: leave HALT.
- `pc_en`  out  1: to PC `pc_en`.
- `branch_taken_out`  out  1: one-cycle pulse to PC `branch_taken_in`.
- `branch_immediate_out`  out  8: to PC `branch_immediate_in`; held stable between accepted branches.
- `flush_out`  out  1: kill wrong-path instructions in fetch/decode.
- `fetch_valid`  out  1: the current PC fetch is on the architectural path.
- `state_out`  out  3: encoded state (debug).
- `stall_cycles_out`  out  16: perf counter (see Configuration).
- `flush_events_out`  out  16: perf counter (see Configuration).

## Operation
- States and `state_out` encoding: IDLE=0, RUN=1, STALL=2, FLUSH=3, HALT=4.
- Outputs are Moore-decoded from the registered state, except `branch_taken_out`, which is a registered pulse.
  - IDLE: `pc_en`=0, `fetch_valid`=0, `flush_out`=0.
  - RUN: `pc_en`=1, `fetch_valid`=1, `flush_out`=0.
  - STALL: `pc_en`=0, `fetch_valid`=0, `flush_out`=0.
  - FLUSH: `pc_en`=1, `fetch_valid`=0, `flush_out`=1.
  - HALT: all three 0.
- IDLE always goes to RUN on the next edge.
- Transitions from RUN and STALL use the priority `branch_req` > `halt_in` > `stall_in`:
  - `branch_req`: go to FLUSH, latch `branch_target` into `branch_immediate_out`, set `branch_taken_out`=1 for exactly one cycle, load flush counter with `FLUSH_CYCLES`-1.
  - else `halt_in`: go to HALT.
  - else `stall_in`: go to (or stay in) STALL.
  - else: go to (or stay in) RUN.
- FLUSH:
  - Counter decrements each edge; at 0, go to RUN.
  - `branch_req`, `halt_in` and `stall_in` are ignored (treated as wrong-path).
  - `pc_en` stays 1 so the PC consumes its delayed branch flag.
- HALT: stays until `resume_in`=1, then goes to RUN. `branch_req` and `stall_in` are ignored.
- Counter width is 4 bits; it never wraps below 0.

## Timing
- `restart` high: immediately state=IDLE. All outputs are 0: `branch_immediate_out`=8'h00, counter=0, perf counters=0.
- After `restart` falls: first edge enters IDLE→RUN; `pc_en`=1 from the second edge.
- Request latency: a request sampled at edge n takes effect on outputs after edge n; the PC sees it at edge n+1.
- `branch_taken_out` is high for the one cycle after acceptance.
- `branch_immediate_out` is stable for at least `FLUSH_CYCLES`+1 edges after acceptance.
- FLUSH lasts exactly `FLUSH_CYCLES` cycles.
- A `restart` asserted mid-FLUSH aborts the flush: pending target is discarded and `branch_taken_out` is cleared.

## Configuration
- `FETCH_SEQ_PERF_EN` defined:
  - `stall_cycles_out` increments every cycle spent in STALL.
  - `flush_events_out` increments per accepted branch.
  - Both are 16-bit, saturate at 16'hFFFF, and clear on `restart`.
- Undefined: both ports are tied to 16'h0000 and no counter logic is built.

## Test plan
- Reset release with no requests → `state_out` 0 then 1; `pc_en`=1 and `fetch_valid`=1 from the 2nd negedge.
- `branch_req`=1 with `branch_target`=8'h3C in RUN:
  - `branch_taken_out` pulses 1 cycle; `branch_immediate_out`=8'h3C.
  - `flush_out`=1 and `pc_en`=1 for 4 cycles, then RUN; `fetch_valid`=1.
- `stall_in` held 3 cycles → `pc_en`=0 for 3 cycles starting 1 edge later, then RUN.
  - With `FETCH_SEQ_PERF_EN`: `stall_cycles_out`=3.
- `branch_req`, `halt_in` and `stall_in` asserted together in RUN → FLUSH taken; HALT and STALL not entered.
  - Second `branch_req`=1, target 8'h10, during FLUSH is ignored; `branch_immediate_out` stays 8'h3C.
- `halt_in`=1 → HALT; `pc_en`=0 held for 10 cycles despite `branch_req`.
  - `resume_in`=1 → RUN next edge.
- `restart` pulsed on the 2nd FLUSH cycle → all outputs 0 asynchronously; IDLE→RUN after release with `branch_immediate_out`=8'h00.
